// File: rtl/vend_pkg.sv
// Shared types and constants for the vending dispense arbiter slice.
// States, coin/price constants and small width helpers.
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DISPENSE,
    PAYOUT,
    DONE,
    FAULT
  } vend_state_t;

  localparam int COIN_UNIT_RS = 5;
  localparam int PRICE_RS     = 20;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Largest change count representable in a chg_w-bit field.
  function automatic int max_change_units(input int chg_w);
    return (1 << chg_w) - 1;
  endfunction

  // Rupee value of a change count expressed in hopper coin units.
  function automatic int change_rs(input int units);
    return units * COIN_UNIT_RS;
  endfunction

endpackage

// File: rtl/vend_rr_arbiter.sv
// Combinational round-robin picker: searches from ptr+1 upward (wrapping)
// and reports the first set request as one-hot, index and an any flag.
// The pointer register lives in the parent.
module vend_rr_arbiter
  import vend_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = cnt_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   index,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  // Walk the requesters in priority order starting just after the last winner.
  always_comb begin
    onehot = '0;
    index  = '0;
    any    = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!any && req[cand]) begin
        any          = 1'b1;
        onehot[cand] = 1'b1;
        index        = cand;
      end
    end
  end

endmodule

// File: rtl/vend_dispense_arbiter.sv
// Shares one dispenser motor and one Rs5 coin hopper among NUM_REQ front-ends.
// A round-robin winner is accepted in IDLE and sequenced DISPENSE -> PAYOUT -> DONE.
// Optional macro VEND_ARB_HOPPER_FAULT_EN adds hopper_empty/fault and a sticky FAULT state.
module vend_dispense_arbiter
  import vend_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DISP_CYCLES = 8,
  parameter int COIN_CYCLES = 4,
  parameter int CHG_W       = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_item,
  input  logic [NUM_REQ*CHG_W-1:0]   req_change,
`ifdef VEND_ARB_HOPPER_FAULT_EN
  input  logic                       hopper_empty,
  output logic                       fault,
`endif
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       motor_on,
  output logic                       hopper_pulse,
  output logic                       busy,
  output logic                       done_valid,
  output logic [$clog2(NUM_REQ)-1:0] done_id
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int DISP_W = cnt_width(DISP_CYCLES);
  localparam int COIN_W = cnt_width(COIN_CYCLES);

  vend_state_t      state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] cap_id;
  logic [CHG_W-1:0] cap_change;
  logic [CHG_W-1:0] coin_cnt;
  logic [DISP_W-1:0] disp_cnt;
  logic [COIN_W-1:0] phase_cnt;

  logic [NUM_REQ-1:0] win_onehot;
  logic [IDX_W-1:0]   win_idx;
  logic               win_any;
  logic               win_item;
  logic [CHG_W-1:0]   win_change;

  vend_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .onehot (win_onehot),
    .index  (win_idx),
    .any    (win_any)
  );

  assign win_item   = req_item[win_idx];
  assign win_change = req_change[win_idx*CHG_W +: CHG_W];

  // The accept strobe exists only while idle; requesters hold their data until they see it.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && win_any) begin
      req_ready = win_onehot;
    end
  end

  // Main sequencer; every coin is scheduled one cycle ahead so hopper_pulse stays registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= IDX_W'(NUM_REQ - 1);
      cap_id       <= '0;
      cap_change   <= '0;
      coin_cnt     <= '0;
      disp_cnt     <= '0;
      phase_cnt    <= '0;
      motor_on     <= 1'b0;
      hopper_pulse <= 1'b0;
      busy         <= 1'b0;
      done_valid   <= 1'b0;
      done_id      <= '0;
`ifdef VEND_ARB_HOPPER_FAULT_EN
      fault        <= 1'b0;
`endif
    end else begin
      hopper_pulse <= 1'b0;
      done_valid   <= 1'b0;
      case (state)
        IDLE: begin
          if (win_any) begin
            rr_ptr     <= win_idx;
            cap_id     <= win_idx;
            cap_change <= win_change;
            busy       <= 1'b1;
            if (win_item) begin
              state    <= DISPENSE;
              motor_on <= 1'b1;
              disp_cnt <= DISP_W'(DISP_CYCLES - 1);
            end else if (win_change != '0) begin
`ifdef VEND_ARB_HOPPER_FAULT_EN
              if (hopper_empty) begin
                state    <= FAULT;
                fault    <= 1'b1;
                coin_cnt <= '0;
              end else
`endif
              begin
                state        <= PAYOUT;
                hopper_pulse <= 1'b1;
                coin_cnt     <= win_change - 1'b1;
                phase_cnt    <= COIN_W'(COIN_CYCLES - 1);
              end
            end else begin
              state      <= DONE;
              done_valid <= 1'b1;
              done_id    <= win_idx;
            end
          end
        end
        DISPENSE: begin
          if (disp_cnt == '0) begin
            motor_on <= 1'b0;
            if (cap_change != '0) begin
`ifdef VEND_ARB_HOPPER_FAULT_EN
              if (hopper_empty) begin
                state    <= FAULT;
                fault    <= 1'b1;
                coin_cnt <= '0;
              end else
`endif
              begin
                state        <= PAYOUT;
                hopper_pulse <= 1'b1;
                coin_cnt     <= cap_change - 1'b1;
                phase_cnt    <= COIN_W'(COIN_CYCLES - 1);
              end
            end else begin
              state      <= DONE;
              done_valid <= 1'b1;
              done_id    <= cap_id;
            end
          end else begin
            disp_cnt <= disp_cnt - 1'b1;
          end
        end
        PAYOUT: begin
          if (phase_cnt != '0) begin
            phase_cnt <= phase_cnt - 1'b1;
          end else if (coin_cnt != '0) begin
`ifdef VEND_ARB_HOPPER_FAULT_EN
            if (hopper_empty) begin
              state    <= FAULT;
              fault    <= 1'b1;
              coin_cnt <= '0;
            end else
`endif
            begin
              hopper_pulse <= 1'b1;
              coin_cnt     <= coin_cnt - 1'b1;
              phase_cnt    <= COIN_W'(COIN_CYCLES - 1);
            end
          end else begin
            state      <= DONE;
            done_valid <= 1'b1;
            done_id    <= cap_id;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= state;
          motor_on <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_dispense_arbiter.sv
// Self-checking bench for vend_dispense_arbiter (NUM_REQ=4, DISP=8, COIN=4, CHG_W=2).
// Table of single transactions plus hand sequences for round-robin, starvation,
// mid-dispense reset and (with VEND_ARB_HOPPER_FAULT_EN) the hopper fault.
module tb_vend_dispense_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DISP    = 8;
  localparam int COIN    = 4;
  localparam int CHG_W   = 2;

  logic                     clk;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_item;
  logic [NUM_REQ*CHG_W-1:0] req_change;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     motor_on;
  logic                     hopper_pulse;
  logic                     busy;
  logic                     done_valid;
  logic [1:0]               done_id;
`ifdef VEND_ARB_HOPPER_FAULT_EN
  logic                     hopper_empty;
  logic                     fault;
`endif

  int checks;
  int failures;

  vend_dispense_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .DISP_CYCLES (DISP),
    .COIN_CYCLES (COIN),
    .CHG_W       (CHG_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_item     (req_item),
    .req_change   (req_change),
`ifdef VEND_ARB_HOPPER_FAULT_EN
    .hopper_empty (hopper_empty),
    .fault        (fault),
`endif
    .req_ready    (req_ready),
    .motor_on     (motor_on),
    .hopper_pulse (hopper_pulse),
    .busy         (busy),
    .done_valid   (done_valid),
    .done_id      (done_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] item;
    logic [7:0] change;
    logic [3:0] exp_ready;
    int         exp_id;
    int         exp_motor;
    int         exp_pulses;
    int         exp_latency;
  } vec_t;

  vec_t vecs[7];

  task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] item, input logic [7:0] change);
    req_valid  = valid;
    req_item   = item;
    req_change = change;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Grant a null job from the IDLE cycle and confirm the DONE strobe next cycle.
  task automatic nullGrant(input string name, input logic [3:0] valid, input int exp_id);
    @(negedge clk);
    applyStimulus(valid, 4'b0000, 8'h00);
    #1;
    checkOutput({name, "_ready"}, req_ready, 32'(1 << exp_id));
    @(negedge clk);
    checkOutput({name, "_done"}, done_valid, 1);
    checkOutput({name, "_id"}, done_id, exp_id);
  endtask

  // Follow one accepted job cycle by cycle against the expected motor/pulse waveform.
  task automatic watchJob(input int exp_motor, input int exp_pulses,
                          output int latency, output int last_id, output int wave_err);
    logic exp_m;
    logic exp_p;
    int   j;
    latency  = -1;
    last_id  = -1;
    wave_err = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 1) applyStimulus(4'b0000, 4'b0000, 8'h00);
      exp_m = (k <= exp_motor);
      j     = k - exp_motor - 1;
      exp_p = (j >= 0) && (j % COIN == 0) && (j / COIN < exp_pulses);
      if (motor_on !== exp_m || hopper_pulse !== exp_p || busy !== 1'b1) wave_err++;
      if (done_valid === 1'b1) begin
        latency = k;
        last_id = int'(done_id);
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int id;
    int werr;
    int bad;

    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 8'h00);
`ifdef VEND_ARB_HOPPER_FAULT_EN
    hopper_empty = 1'b0;
`endif

    // Transactions in order; rr pointer starts at 3 after reset.
    vecs[0] = '{4'b0001, 4'b0001, 8'h02, 4'b0001, 0, 8, 2, 17};
    vecs[1] = '{4'b0010, 4'b0000, 8'h0C, 4'b0010, 1, 0, 3, 13};
    vecs[2] = '{4'b1111, 4'b0000, 8'h00, 4'b0100, 2, 0, 0, 1};
    vecs[3] = '{4'b1011, 4'b1011, 8'h00, 4'b1000, 3, 8, 0, 9};
    vecs[4] = '{4'b0110, 4'b0010, 8'h34, 4'b0010, 1, 8, 1, 13};
    vecs[5] = '{4'b0011, 4'b0000, 8'h09, 4'b0001, 0, 0, 1, 5};
    vecs[6] = '{4'b1000, 4'b1000, 8'hC0, 4'b1000, 3, 8, 3, 21};

    repeat (3) @(negedge clk);
    checkOutput("rst_motor", motor_on, 0);
    checkOutput("rst_pulse", hopper_pulse, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done_valid, 0);
    checkOutput("rst_id", done_id, 0);
    rst = 1'b0;
    #1;
    checkOutput("rst_ready", req_ready, 0);

    // All four requesters valid with null jobs: strict rotation every two cycles.
    nullGrant("rr0", 4'b1111, 0);
    nullGrant("rr1", 4'b1111, 1);
    nullGrant("rr2", 4'b1111, 2);
    nullGrant("rr3", 4'b1111, 3);
    nullGrant("rr4", 4'b1111, 0);
    applyStimulus(4'b0000, 4'b0000, 8'h00);

    doReset();
    for (int v = 0; v < 7; v++) begin
      @(negedge clk);
      applyStimulus(vecs[v].valid, vecs[v].item, vecs[v].change);
      #1;
      checkOutput($sformatf("v%0d_ready", v), req_ready, vecs[v].exp_ready);
      watchJob(vecs[v].exp_motor, vecs[v].exp_pulses, lat, id, werr);
      checkOutput($sformatf("v%0d_latency", v), lat, vecs[v].exp_latency);
      checkOutput($sformatf("v%0d_id", v), id, vecs[v].exp_id);
      checkOutput($sformatf("v%0d_wave", v), werr, 0);
      @(negedge clk);
      checkOutput($sformatf("v%0d_idle_done", v), done_valid, 0);
      checkOutput($sformatf("v%0d_idle_busy", v), busy, 0);
    end

    // Held requests around req3 (pointer ends at 3 after the table).
    nullGrant("sv0", 4'b0100, 2);
    nullGrant("sv1", 4'b1100, 3);
    nullGrant("sv2", 4'b1101, 0);
    nullGrant("sv3", 4'b1100, 2);
    nullGrant("sv4", 4'b1100, 3);
    nullGrant("sv5", 4'b0100, 2);
    applyStimulus(4'b0000, 4'b0000, 8'h00);

    // Reset while the motor is running aborts the job silently.
    @(negedge clk);
    applyStimulus(4'b0001, 4'b0001, 8'h00);
    @(negedge clk);
    applyStimulus(4'b0000, 4'b0000, 8'h00);
    repeat (2) @(negedge clk);
    checkOutput("mid_motor_on", motor_on, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_motor_off", motor_on, 0);
    checkOutput("mid_busy", busy, 0);
    checkOutput("mid_done", done_valid, 0);
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done_valid !== 1'b0 || motor_on !== 1'b0 || busy !== 1'b0) bad++;
    end
    checkOutput("mid_quiet", bad, 0);
    nullGrant("mid_ptr", 4'b1111, 0);
    applyStimulus(4'b0000, 4'b0000, 8'h00);

`ifdef VEND_ARB_HOPPER_FAULT_EN
    // Hopper runs dry before the second of three coins.
    doReset();
    @(negedge clk);
    applyStimulus(4'b0010, 4'b0000, 8'h0C);
    #1;
    checkOutput("flt_ready", req_ready, 4'b0010);
    bad = 0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) applyStimulus(4'b1111, 4'b0000, 8'h00);
      if (k == 2) hopper_empty = 1'b1;
      if (hopper_pulse === 1'b1) lat++;
      if (done_valid !== 1'b0 || req_ready !== 4'b0000) bad++;
    end
    checkOutput("flt_pulses", lat, 1);
    checkOutput("flt_quiet", bad, 0);
    checkOutput("flt_fault", fault, 1);
    checkOutput("flt_busy", busy, 1);
    rst = 1'b1;
    hopper_empty = 1'b0;
    applyStimulus(4'b0000, 4'b0000, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("flt_clear", fault, 0);
    checkOutput("flt_clear_busy", busy, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout actual=running expected=finished");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
